// File: rtl/charset.sv
// -----------------------------------------------------------------------------
// charset -- programmable character-set table
//
// Stores up to 63 seven-bit characters, which are appended one per clock.
// A character is read back by its ordinal. Ordinals at or beyond the current
// set length read as 7'h00, so old contents left over from an earlier fill
// can never be seen. Each string position of the brute-force string
// generator uses one instance. The generator steps `ord` through 0..len-1
// and joins the returned characters into the candidate string.
//
// Configuration macro:
//   CHARSET_REG_OUT_EN  undefined (default): char_out is combinational and has
//                       zero latency from ord. The string generator needs
//                       this build.
//                       defined: char_out is registered. It shows the read
//                       result from the previous edge, which gives one cycle
//                       of latency. The register clears to 7'h00 on reset.
//
// Ports:
//   clk       in   1  single clock, rising edge
//   reset     in   1  synchronous, active-high; clears the set length
//   w_en      in   1  append strobe (one character per cycle)
//   w_char    in   7  character to append
//   ord       in   6  ordinal of the character to read
//   len       out  6  number of valid characters stored (0..63)
//   char_out  out  7  character at ord, or 7'h00 when ord >= len
// -----------------------------------------------------------------------------
module charset (
    input  logic       clk,
    input  logic       reset,
    input  logic       w_en,
    input  logic [6:0] w_char,
    input  logic [5:0] ord,
    output logic [5:0] len,
    output logic [6:0] char_out
);

    localparam logic [5:0] LEN_FULL = 6'd63;

    logic [6:0] mem [0:63];
    logic       is_full;
    logic       do_write;
    logic [6:0] read_char;

    assign is_full  = (len == LEN_FULL);
    // Reset takes priority, so a write strobe in the same cycle is dropped.
    assign do_write = w_en && !reset && !is_full;

    // NOTE: sequential state uses non-blocking assignments. Every register
    // then samples the pre-edge values, whatever order the blocks run in.
    always_ff @(posedge clk) begin
        if (reset) begin
            len <= '0;
        end else if (do_write) begin
            len <= len + 6'd1;
        end
    end

    // NOTE: the storage array is deliberately not reset. The read mask on len
    // hides stale entries, and leaving out the reset lets the array map onto
    // plain RAM.
    always_ff @(posedge clk) begin
        if (do_write) begin
            mem[len] <= w_char;
        end
    end

    // NOTE: read_char is given a default first, so no path through this block
    // can infer a latch.
    always_comb begin
        read_char = 7'h00;
        if (ord < len) begin
            read_char = mem[ord];
        end
    end

`ifdef CHARSET_REG_OUT_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            char_out <= 7'h00;
        end else begin
            char_out <= read_char;
        end
    end
`else
    assign char_out = read_char;
`endif

endmodule

// File: tb/tb_charset.sv
// -----------------------------------------------------------------------------
// tb_charset -- self-checking bench for charset
//
// Directed steps run from a single initial block. Each expected value goes
// onto a scoreboard queue when its stimulus is driven. It is popped and
// compared once the DUT output is valid. Inputs change 1 ns after a rising
// edge and outputs are sampled 1 ns later, well away from the active edge.
// -----------------------------------------------------------------------------
module tb_charset;

    logic       clk = 1'b0;
    logic       reset;
    logic       w_en;
    logic [6:0] w_char;
    logic [5:0] ord;
    logic [5:0] len;
    logic [6:0] char_out;

    int tests_run = 0;
    int tests_failed = 0;

    logic [6:0] exp_char_q [$];
    logic [5:0] exp_len_q [$];

    charset dut (
        .clk      (clk),
        .reset    (reset),
        .w_en     (w_en),
        .w_char   (w_char),
        .ord      (ord),
        .len      (len),
        .char_out (char_out)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_char(input logic [6:0] c);
        w_en   = 1'b1;
        w_char = c;
        tick();
        w_en   = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    task automatic check_len(input logic [5:0] expected, input string tag);
        logic [5:0] e;
        exp_len_q.push_back(expected);
        #1;
        e = exp_len_q.pop_front();
        tests_run++;
        assert (len === e) else begin
            tests_failed++;
            $error("FAIL %s: len observed %0d expected %0d", tag, len, e);
        end
    endtask

    // Drive ord, wait until the read result is valid, then compare it.
    task automatic check_char(input logic [5:0] o, input logic [6:0] expected,
                              input string tag);
        logic [6:0] e;
        ord = o;
        exp_char_q.push_back(expected);
`ifdef CHARSET_REG_OUT_EN
        tick();
`else
        #1;
`endif
        e = exp_char_q.pop_front();
        tests_run++;
        assert (char_out === e) else begin
            tests_failed++;
            $error("FAIL %s: char_out observed %h expected %h", tag, char_out, e);
        end
    endtask

    initial begin
        reset  = 1'b0;
        w_en   = 1'b0;
        w_char = 7'h00;
        ord    = 6'd0;
        tick();

        // Reset
        do_reset();
        check_len(6'd0, "reset_len");
        check_char(6'd0,  7'h00, "reset_ord0");
        check_char(6'd5,  7'h00, "reset_ord5");
        check_char(6'd63, 7'h00, "reset_ord63");

        // Append and read
        write_char(7'h61);
        write_char(7'h62);
        write_char(7'h63);
        check_len(6'd3, "abc_len");
        check_char(6'd0, 7'h61, "abc_ord0");
        check_char(6'd1, 7'h62, "abc_ord1");
        check_char(6'd2, 7'h63, "abc_ord2");
        check_char(6'd3, 7'h00, "abc_ord3");

        // Simultaneous reset and write: reset wins
        reset  = 1'b1;
        w_en   = 1'b1;
        w_char = 7'h41;
        tick();
        reset  = 1'b0;
        w_en   = 1'b0;
        check_len(6'd0, "rstwr_len");
        check_char(6'd0, 7'h00, "rstwr_ord0");
        write_char(7'h42);
        check_len(6'd1, "rstwr_next_len");
        check_char(6'd0, 7'h42, "rstwr_next_ord0");

        // Re-fill after reset: old entry at index 1 (7'h62) stays masked
        do_reset();
        write_char(7'h30);
        check_len(6'd1, "refill_len");
        check_char(6'd0, 7'h30, "refill_ord0");
        check_char(6'd1, 7'h00, "refill_ord1_masked");

`ifndef CHARSET_REG_OUT_EN
        // Same-cycle write and read: pre-edge view, then visible right after the edge
        do_reset();
        ord    = 6'd0;
        w_en   = 1'b1;
        w_char = 7'h55;
        #1;
        tests_run++;
        assert (char_out === 7'h00) else begin
            tests_failed++;
            $error("FAIL same_cycle_pre: char_out observed %h expected %h", char_out, 7'h00);
        end
        tick();
        w_en = 1'b0;
        check_char(6'd0, 7'h55, "same_cycle_post");
`endif

        // Full
        do_reset();
        for (int i = 0; i < 63; i++) begin
            write_char(7'(7'h20 + i));
        end
        check_len(6'd63, "full_len");
        write_char(7'h7F);
        check_len(6'd63, "full_no_wrap");
        check_char(6'd62, 7'h5E, "full_ord62");
        check_char(6'd63, 7'h00, "full_ord63");
        check_char(6'd0,  7'h20, "full_ord0_kept");

`ifdef CHARSET_REG_OUT_EN
        // Registered build: ord changes after edge N, output follows only after edge N+1
        ord = 6'd0;
        tick();
        ord = 6'd1;
        #1;
        tests_run++;
        assert (char_out === 7'h20) else begin
            tests_failed++;
            $error("FAIL reg_latency_hold: char_out observed %h expected %h", char_out, 7'h20);
        end
        tick();
        tests_run++;
        assert (char_out === 7'h21) else begin
            tests_failed++;
            $error("FAIL reg_latency_update: char_out observed %h expected %h", char_out, 7'h21);
        end
        do_reset();
        tests_run++;
        assert (char_out === 7'h00) else begin
            tests_failed++;
            $error("FAIL reg_reset: char_out observed %h expected %h", char_out, 7'h00);
        end
`endif

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
